// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the frame-buffer read path.
package fb_pkg;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    STREAM   = 2'd2,
    DRAIN    = 2'd3
  } fb_state_t;

endpackage

// File: rtl/fb_sync_fifo.sv
// Single-clock return FIFO; the head entry is presented straight from storage flops.
module fb_sync_fifo #(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW         = $clog2(FIFO_DEPTH),
  localparam int unsigned CW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a push into a full FIFO is fine when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_scan_rd.sv
// Frame-buffer read master: credit-limited word requests, return FIFO and
// a marked pixel stream (sof/eol/eof) for the output stage.
module frame_scan_rd
  import fb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned H_PIXELS   = 8,
  parameter int unsigned V_LINES    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  buf_rdy,
  output logic                  rd_en_l,
  input  logic                  rd_data_valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_eof,
  output logic                  busy,
  output logic                  done,
  output logic                  err_ovf
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_WIDTH-1:0] N_WORDS = CNT_WIDTH'(H_PIXELS * V_LINES);
  localparam logic [CNT_WIDTH-1:0] X_LAST  = CNT_WIDTH'(H_PIXELS - 1);
  localparam logic [CNT_WIDTH-1:0] Y_LAST  = CNT_WIDTH'(V_LINES - 1);

  fb_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0] req_cnt_q;
  logic [CNT_WIDTH-1:0] req_pend;
  logic [CNT_WIDTH-1:0] x_q, y_q;
  logic [CW-1:0]        outst_q;
  logic [CW-1:0]        fifo_cnt;
  logic [CW:0]          credit;
  logic                 rd_en_l_q;
  logic                 done_q;
  logic                 err_ovf_q;
  logic                 req_now;
  logic                 ret_ok;
  logic                 ret_bad;
  logic                 issue;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 at_eol;
  logic                 at_eof;
  logic                 eof_pop;
  logic                 frame_go;

  assign req_now  = (rd_en_l_q == ASSERT_L);
  assign ret_ok   = rd_data_valid && (outst_q != '0);
  assign ret_bad  = rd_data_valid && (outst_q == '0);
  assign frame_go = (state_q == IDLE) && start;

  // the request being issued this cycle has not reached req_cnt/outst yet
  assign req_pend = req_cnt_q + {{(CNT_WIDTH-1){1'b0}}, req_now};
  assign credit   = {1'b0, outst_q} + {1'b0, fifo_cnt} + {{CW{1'b0}}, req_now};
  assign issue    = (state_q == STREAM) && (req_pend < N_WORDS)
                    && (credit < (CW+1)'(FIFO_DEPTH));

  assign pix_valid = !fifo_empty;
  assign pop       = pix_valid && pix_ready;
  assign at_eol    = (x_q == X_LAST);
  assign at_eof    = at_eol && (y_q == Y_LAST);
  assign eof_pop   = pop && at_eof;

  fb_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ret_ok && (!fifo_full || pop)),
    .push_data (rd_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt),
    .head      (pix_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = WAIT_RDY;
      WAIT_RDY: if (buf_rdy) state_d = STREAM;
      STREAM: begin
        if (eof_pop)                  state_d = IDLE;
        else if (req_cnt_q == N_WORDS) state_d = DRAIN;
      end
      DRAIN:    if (eof_pop) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rd_en_l_q <= DEASSERT_L;
      req_cnt_q <= '0;
      outst_q   <= '0;
      done_q    <= DEASSERT_H;
      err_ovf_q <= DEASSERT_H;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      rd_en_l_q <= issue ? ASSERT_L : DEASSERT_L;
      done_q    <= eof_pop ? ASSERT_H : DEASSERT_H;

      if (frame_go)     req_cnt_q <= '0;
      else if (req_now) req_cnt_q <= req_cnt_q + 1'b1;

      case ({req_now, ret_ok})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase

      if (ret_bad) err_ovf_q <= ASSERT_H;

      if (frame_go) begin
        x_q <= '0;
        y_q <= '0;
      end else if (pop) begin
        if (at_eol) begin
          x_q <= '0;
          y_q <= at_eof ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  assign rd_en_l = rd_en_l_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign err_ovf = err_ovf_q;
  assign pix_sof = pix_valid && (x_q == '0) && (y_q == '0);
  assign pix_eol = pix_valid && at_eol;
  assign pix_eof = pix_valid && at_eof;

endmodule

// File: tb/tb_frame_scan_rd.sv
// Directed bench for frame_scan_rd with a 1-cycle-latency frame-buffer model.
module tb_frame_scan_rd;

  localparam int unsigned DW    = 32;
  localparam int unsigned HP    = 8;
  localparam int unsigned VL    = 4;
  localparam int unsigned NPIX  = HP * VL;
  localparam int unsigned LIMIT = 400;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          buf_rdy;
  logic          rd_en_l;
  logic          rd_data_valid;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_sof;
  logic          pix_eol;
  logic          pix_eof;
  logic          busy;
  logic          done;
  logic          err_ovf;

  logic          spur;
  logic          pend;
  logic [DW-1:0] addr;

  int unsigned tests;
  int unsigned fails;

  frame_scan_rd #(
    .DATA_WIDTH (DW),
    .H_PIXELS   (HP),
    .V_LINES    (VL),
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .start         (start),
    .buf_rdy       (buf_rdy),
    .rd_en_l       (rd_en_l),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_sof       (pix_sof),
    .pix_eol       (pix_eol),
    .pix_eof       (pix_eof),
    .busy          (busy),
    .done          (done),
    .err_ovf       (err_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory: a low rd_en_l in cycle t returns word 'addr' in cycle t+1
  always @(negedge clk) begin
    if (!rst_n) begin
      pend          <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
      addr          <= '0;
    end else if (spur) begin
      rd_data_valid <= 1'b1;
      rd_data       <= 32'hDEAD_BEEF;
      pend          <= 1'b0;
    end else begin
      rd_data_valid <= pend;
      rd_data       <= addr;
      if (pend)       addr <= addr + 1'b1;
      else if (!busy) addr <= '0;
      pend <= (rd_en_l == 1'b0);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_en_l", rd_en_l, 1);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_sof", pix_sof, 0);
    check("rst_eol", pix_eol, 0);
    check("rst_eof", pix_eof, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_ovf", err_ovf, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs a frame from the WAIT_RDY cycle until 'target' pixels are accepted.
  task automatic run_frame(input int unsigned stall_from, input int unsigned stall_to,
                           input int unsigned target, input int unsigned start_at,
                           output int unsigned first_req, output int unsigned first_pix,
                           output int unsigned nreq, output int unsigned max_infl);
    int unsigned cyc;
    int unsigned pops;
    int unsigned infl;
    logic        held_v;
    logic [DW-1:0] held;
    cyc = 0; pops = 0; held_v = 1'b0; held = '0;
    first_req = 0; first_pix = 0; nreq = 0; max_infl = 0;
    while (pops < target && cyc < LIMIT) begin
      tick();
      cyc++;
      start     = (cyc == start_at);
      pix_ready = !(cyc >= stall_from && cyc <= stall_to);
      if (rd_en_l == 1'b0) begin
        nreq++;
        if (first_req == 0) first_req = cyc;
      end
      infl = nreq - pops;
      if (infl > max_infl) max_infl = infl;
      if (pix_valid) begin
        if (first_pix == 0) first_pix = cyc;
        if (held_v) check("stall_hold_data", pix_data, held);
        if (pix_ready) begin
          check("pix_data", pix_data, pops);
          check("pix_sof", pix_sof, pops == 0);
          check("pix_eol", pix_eol, (pops % HP) == HP - 1);
          check("pix_eof", pix_eof, pops == NPIX - 1);
          pops++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held   = pix_data;
        end
      end else if (held_v) begin
        check("stall_hold_valid", pix_valid, 1);
        held_v = 1'b0;
      end
    end
    start = 1'b0;
    check("frame_pixel_count", pops, target);
    if (target == NPIX) begin
      tick();
      check("done_pulse", done, 1);
      check("busy_fall", busy, 0);
      check("empty_after_frame", pix_valid, 0);
      tick();
      check("done_one_cycle", done, 0);
    end
  endtask

  int unsigned first_req, first_pix, nreq, max_infl;

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; start = 1'b0; buf_rdy = 1'b0; pix_ready = 1'b0; spur = 1'b0;

    // 1: reset state and a basic frame
    tick(); tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();
    buf_rdy = 1'b1;
    pulse_start();
    check("busy_after_start", busy, 1);
    run_frame(1, 0, NPIX, 0, first_req, first_pix, nreq, max_infl);
    check("t1_first_req", first_req, 2);
    check("t1_first_pix", first_pix, 4);
    check("t1_req_total", nreq, NPIX);
    tick();

    // 2: late buffer
    buf_rdy = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      check("wait_rd_en_l", rd_en_l, 1);
      check("wait_pix_valid", pix_valid, 0);
      check("wait_busy", busy, 1);
      tick();
    end
    buf_rdy = 1'b1;
    run_frame(1, 0, NPIX, 0, first_req, first_pix, nreq, max_infl);
    check("t2_first_req", first_req, 2);
    check("t2_first_pix", first_pix, 4);
    check("t2_req_total", nreq, NPIX);
    tick();

    // 3: backpressure
    pulse_start();
    run_frame(5, 20, NPIX, 0, first_req, first_pix, nreq, max_infl);
    check("t3_inflight_max", max_infl, 4);
    check("t3_req_total", nreq, NPIX);
    tick();

    // 4: spurious return in IDLE
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick(); tick();
    check("spur_err_ovf", err_ovf, 1);
    check("spur_fifo_empty", pix_valid, 0);
    check("spur_idle", busy, 0);
    tick(); tick();
    check("spur_err_sticky", err_ovf, 1);
    pulse_start();
    run_frame(1, 0, NPIX, 0, first_req, first_pix, nreq, max_infl);
    check("t4_req_total", nreq, NPIX);
    check("t4_err_still_set", err_ovf, 1);
    tick();

    // 5: reset mid-frame after pixel 12
    pulse_start();
    run_frame(1, 0, 13, 0, first_req, first_pix, nreq, max_infl);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", busy, 0);
    pulse_start();
    run_frame(1, 0, NPIX, 0, first_req, first_pix, nreq, max_infl);
    check("t5_req_total", nreq, NPIX);
    tick();

    // 6: start while busy is ignored
    pulse_start();
    run_frame(1, 0, NPIX, 10, first_req, first_pix, nreq, max_infl);
    check("t6_req_total", nreq, NPIX);
    tick();
    check("t6_stays_idle", busy, 0);
    check("t6_no_request", rd_en_l, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
